// File: rtl/branch_resolve_unit_pkg.sv
// Shared widths, queue-entry layout and the PC increment for the branch resolve unit.
package branch_resolve_unit_pkg;

  localparam int WIDTH_PC = 32;

  // Entry layout, LSB first: predicted target, effective taken, branch PC.
  localparam int ENT_TGT_BIT   = 0;
  localparam int ENT_TAKEN_BIT = WIDTH_PC;
  localparam int ENT_PC_BIT    = WIDTH_PC + 1;
  localparam int ENT_WIDTH     = 2 * WIDTH_PC + 1;

  localparam logic [WIDTH_PC-1:0] PC_INC = WIDTH_PC'(4);

  typedef logic [WIDTH_PC-1:0] pc_t;

  typedef struct packed {
    pc_t  pc;
    logic taken;
    pc_t  tgt;
  } ent_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Prediction, resolution and update/redirect bundle; stats signals exist only with BRU_STATS_EN.
interface branch_resolve_unit_if;
  import branch_resolve_unit_pkg::*;

  logic pred_valid;
  pc_t  pred_pc;
  logic pred_hit;
  logic pred_taken;
  pc_t  pred_target;
  logic pred_ready;

  logic res_valid;
  logic res_taken;
  pc_t  res_target;

  logic upd_valid;
  logic upd_wrong;
  pc_t  upd_pc;
  pc_t  upd_target;

  logic redirect_valid;
  pc_t  redirect_pc;
  logic flush;
  logic underflow_err;

`ifdef BRU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  modport master (
    output pred_valid, pred_pc, pred_hit, pred_taken, pred_target,
    input  pred_ready,
    output res_valid, res_taken, res_target,
    input  upd_valid, upd_wrong, upd_pc, upd_target,
    input  redirect_valid, redirect_pc, flush, underflow_err
`ifdef BRU_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );

  modport slave (
    input  pred_valid, pred_pc, pred_hit, pred_taken, pred_target,
    output pred_ready,
    input  res_valid, res_taken, res_target,
    output upd_valid, upd_wrong, upd_pc, upd_target,
    output redirect_valid, redirect_pc, flush, underflow_err
`ifdef BRU_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );

endinterface

// File: rtl/branch_resolve_unit_pred_fifo.sv
// Generic DEPTH x W FIFO with synchronous clear; head is a combinational read of the oldest entry.
// A push while full is taken only if a pop frees the slot in the same cycle.
module bru_pred_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  input  logic         clear,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty & ~clear;
  assign do_push  = push & (~full | do_pop) & ~clear;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks in-flight branch predictions, compares against EX outcome; update/redirect/flush registered 1 cycle after res_valid.
// pred_ready drops when the queue is full; optional counters under BRU_STATS_EN.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus
);

  ent_t head;
  ent_t push_ent;
  logic [ENT_WIDTH-1:0] head_raw;
  logic full;
  logic empty;
  logic pop_en;
  logic push_en;
  logic wrong;

  logic upd_valid_q;
  logic upd_wrong_q;
  pc_t  upd_pc_q;
  pc_t  upd_target_q;
  logic redirect_valid_q;
  pc_t  redirect_pc_q;
  logic flush_q;
  logic underflow_q;

  // The flush cycle belongs to the wrong path: neither side may touch the queue.
  assign pop_en  = bus.res_valid & ~empty & ~flush_q;
  assign push_en = bus.pred_valid & ~flush_q;

  assign push_ent = '{pc:    bus.pred_pc,
                      taken: bus.pred_hit & bus.pred_taken,
                      tgt:   bus.pred_target};
  assign head = ent_t'(head_raw);

  bru_pred_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (ENT_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_en),
    .push_dat (push_ent),
    .pop      (pop_en),
    .clear    (flush_q),
    .head_dat (head_raw),
    .full     (full),
    .empty    (empty)
  );

  // Target only matters when both sides agree the branch was taken.
  assign wrong = (head.taken != bus.res_taken) |
                 (bus.res_taken & head.taken & (head.tgt != bus.res_target));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid_q      <= 1'b0;
      upd_wrong_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_target_q     <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      underflow_q      <= 1'b0;
    end else begin
      upd_valid_q      <= pop_en;
      upd_wrong_q      <= pop_en & wrong;
      upd_pc_q         <= pop_en ? head.pc : '0;
      upd_target_q     <= pop_en ? bus.res_target : '0;
      redirect_valid_q <= pop_en & wrong;
      flush_q          <= pop_en & wrong;
      if (pop_en & wrong)
        redirect_pc_q <= bus.res_taken ? bus.res_target : head.pc + PC_INC;
      else
        redirect_pc_q <= '0;
      if (bus.res_valid & empty & ~flush_q)
        underflow_q <= 1'b1;
    end
  end

  assign bus.pred_ready     = ~full;
  assign bus.upd_valid      = upd_valid_q;
  assign bus.upd_wrong      = upd_wrong_q;
  assign bus.upd_pc         = upd_pc_q;
  assign bus.upd_target     = upd_target_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.underflow_err  = underflow_q;

`ifdef BRU_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] mp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (upd_valid_q && br_cnt != '1) br_cnt <= br_cnt + 32'd1;
      if (upd_wrong_q && mp_cnt != '1) mp_cnt <= mp_cnt + 32'd1;
    end
  end

  assign bus.stat_branches    = br_cnt;
  assign bus.stat_mispredicts = mp_cnt;
`endif

endmodule
